// File: rtl/cpu_pkg.sv
// Shared datapath widths and register-file constants for the writeback stage.
// No logic; constants only.
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO      = 5'd0;
  localparam logic [DATA_W-1:0] REG_RESET_VAL = '0;
endpackage

// File: rtl/wb_select_mux.sv
// Writeback value select: load data when MemtoReg_in, otherwise ALU result.
// Combinational, zero latency; no backpressure.
module wb_select_mux #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              MemtoReg_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] MemReadData_in,
  output logic [DATA_W-1:0] WriteData_out
);
  assign WriteData_out = MemtoReg_in ? MemReadData_in : ALUResult_in;
endmodule

// File: rtl/wb_register_file.sv
// 32-entry register file fed by MEM/WB, two async read ports with write bypass, commit counter.
// Writes commit on the next edge, reads are zero-latency; no backpressure, one write per cycle.
module wb_register_file #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int CNT_W    = 32
) (
  input  logic              Clk_in,
  input  logic              Reset_n_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] MemReadData_in,
  input  logic [ADDR_W-1:0] WriteReg_in,
  input  logic [ADDR_W-1:0] ReadReg1_in,
  input  logic [ADDR_W-1:0] ReadReg2_in,
  output logic [DATA_W-1:0] ReadData1_out,
  output logic [DATA_W-1:0] ReadData2_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [CNT_W-1:0]  WriteCount_out
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] write_dat;
  logic [CNT_W-1:0]  write_cnt;
  logic              commit_vld;

  wb_select_mux #(.DATA_W(DATA_W)) u_select (
    .MemtoReg_in    (MemtoReg_in),
    .ALUResult_in   (ALUResult_in),
    .MemReadData_in (MemReadData_in),
    .WriteData_out  (write_dat)
  );

  assign commit_vld = Reset_n_in && RegWrite_in && (WriteReg_in != ADDR_W'(REG_ZERO));

  always_ff @(posedge Clk_in) begin
    if (!Reset_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= DATA_W'(REG_RESET_VAL);
      end
      write_cnt <= '0;
    end else if (commit_vld) begin
      regs[WriteReg_in] <= write_dat;
      write_cnt         <= write_cnt + 1'b1;
    end
  end

  // Write-first bypass: a committing write is visible on the read ports in the same cycle.
  always_comb begin
    ReadData1_out = '0;
    ReadData2_out = '0;
    if (Reset_n_in) begin
      if (ReadReg1_in == ADDR_W'(REG_ZERO)) begin
        ReadData1_out = '0;
      end else if (commit_vld && (ReadReg1_in == WriteReg_in)) begin
        ReadData1_out = write_dat;
      end else begin
        ReadData1_out = regs[ReadReg1_in];
      end
      if (ReadReg2_in == ADDR_W'(REG_ZERO)) begin
        ReadData2_out = '0;
      end else if (commit_vld && (ReadReg2_in == WriteReg_in)) begin
        ReadData2_out = write_dat;
      end else begin
        ReadData2_out = regs[ReadReg2_in];
      end
    end
  end

  assign WriteData_out  = write_dat;
  assign WriteCount_out = write_cnt;
endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file; a narrow-counter instance exercises counter wrap.
module tb_wb_register_file;
  logic        Clk_in = 1'b0;
  logic        Reset_n_in;
  logic        MemtoReg_in;
  logic        RegWrite_in;
  logic [31:0] ALUResult_in;
  logic [31:0] MemReadData_in;
  logic [4:0]  WriteReg_in;
  logic [4:0]  ReadReg1_in;
  logic [4:0]  ReadReg2_in;
  logic [31:0] ReadData1_out, ReadData2_out, WriteData_out, WriteCount_out;
  logic [31:0] s_rd1, s_rd2, s_wd;
  logic [3:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 Clk_in = ~Clk_in;

  wb_register_file dut (
    .Clk_in(Clk_in), .Reset_n_in(Reset_n_in), .MemtoReg_in(MemtoReg_in),
    .RegWrite_in(RegWrite_in), .ALUResult_in(ALUResult_in), .MemReadData_in(MemReadData_in),
    .WriteReg_in(WriteReg_in), .ReadReg1_in(ReadReg1_in), .ReadReg2_in(ReadReg2_in),
    .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
    .WriteData_out(WriteData_out), .WriteCount_out(WriteCount_out)
  );

  wb_register_file #(.CNT_W(4)) dut_small (
    .Clk_in(Clk_in), .Reset_n_in(Reset_n_in), .MemtoReg_in(MemtoReg_in),
    .RegWrite_in(RegWrite_in), .ALUResult_in(ALUResult_in), .MemReadData_in(MemReadData_in),
    .WriteReg_in(WriteReg_in), .ReadReg1_in(ReadReg1_in), .ReadReg2_in(ReadReg2_in),
    .ReadData1_out(s_rd1), .ReadData2_out(s_rd2),
    .WriteData_out(s_wd), .WriteCount_out(s_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_in);
    @(negedge Clk_in);
  endtask

  task automatic drive_wr(input logic we, input logic m2r, input logic [4:0] wr,
                          input logic [31:0] alu, input logic [31:0] mem);
    RegWrite_in    = we;
    MemtoReg_in    = m2r;
    WriteReg_in    = wr;
    ALUResult_in   = alu;
    MemReadData_in = mem;
  endtask

  initial begin
    Reset_n_in  = 1'b0;
    ReadReg1_in = 5'd0;
    ReadReg2_in = 5'd0;
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

    // Reset held for two edges, with a write presented that must be discarded
    @(negedge Clk_in);
    drive_wr(1'b1, 1'b0, 5'd5, 32'h0000_0055, 32'h0);
    ReadReg1_in = 5'd5;
    ReadReg2_in = 5'd5;
    #1;
    check("rst_rd1_forced0", 64'(ReadData1_out), 64'h0);
    check("rst_rd2_forced0", 64'(ReadData2_out), 64'h0);
    check("rst_wdata_mux", 64'(WriteData_out), 64'h55);
    tick();
    tick();
    Reset_n_in = 1'b1;
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int r = 1; r < 32; r++) begin
      ReadReg1_in = 5'(r);
      ReadReg2_in = 5'(r);
      #1;
      check($sformatf("rst_reg%0d", r), {ReadData1_out, ReadData2_out}, 64'h0);
    end
    check("rst_count", 64'(WriteCount_out), 64'h0);

    // ALU-result write, then load-data write
    drive_wr(1'b1, 1'b0, 5'd8, 32'hDEAD_BEEF, 32'hAAAA_AAAA);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    ReadReg1_in = 5'd8;
    #1;
    check("alu_wr_r8", 64'(ReadData1_out), 64'hDEAD_BEEF);
    check("alu_wr_count", 64'(WriteCount_out), 64'd1);
    drive_wr(1'b1, 1'b1, 5'd9, 32'h0000_0BAD, 32'h1234_5678);
    #1;
    check("mem_wdata_mux", 64'(WriteData_out), 64'h1234_5678);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    ReadReg2_in = 5'd9;
    #1;
    check("mem_wr_r9", 64'(ReadData2_out), 64'h1234_5678);
    check("mem_wr_count", 64'(WriteCount_out), 64'd2);

    // Bypass on both ports vs. no-commit
    ReadReg1_in = 5'd5;
    ReadReg2_in = 5'd5;
    drive_wr(1'b0, 1'b0, 5'd5, 32'h0000_CAFE, 32'h0);
    #1;
    check("nobyp_rd1_old", 64'(ReadData1_out), 64'h0);
    check("nobyp_rd2_old", 64'(ReadData2_out), 64'h0);
    RegWrite_in = 1'b1;
    #1;
    check("byp_rd1", 64'(ReadData1_out), 64'h0000_CAFE);
    check("byp_rd2", 64'(ReadData2_out), 64'h0000_CAFE);
    tick();
    drive_wr(1'b0, 1'b0, 5'd5, 32'h0000_1111, 32'h0);
    #1;
    check("nobyp_rd1_stored", 64'(ReadData1_out), 64'h0000_CAFE);
    check("nobyp_rd2_stored", 64'(ReadData2_out), 64'h0000_CAFE);
    check("byp_count", 64'(WriteCount_out), 64'd3);

    // Register 0 protection
    ReadReg1_in = 5'd0;
    ReadReg2_in = 5'd0;
    drive_wr(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
    #1;
    check("r0_nobyp_rd1", 64'(ReadData1_out), 64'h0);
    check("r0_nobyp_rd2", 64'(ReadData2_out), 64'h0);
    check("r0_wdata", 64'(WriteData_out), 64'hFFFF_FFFF);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check("r0_read", 64'(ReadData1_out), 64'h0);
    check("r0_count", 64'(WriteCount_out), 64'd3);

    // Back-to-back writes to one index: last edge wins
    drive_wr(1'b1, 1'b0, 5'd10, 32'h0000_0001, 32'h0);
    tick();
    drive_wr(1'b1, 1'b0, 5'd10, 32'h0000_0002, 32'h0);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    ReadReg1_in = 5'd10;
    #1;
    check("b2b_r10", 64'(ReadData1_out), 64'h2);
    check("b2b_count", 64'(WriteCount_out), 64'd5);

    // Reset mid-stream
    drive_wr(1'b1, 1'b0, 5'd3, 32'h0000_0007, 32'h0);
    tick();
    ReadReg1_in = 5'd3;
    ReadReg2_in = 5'd4;
    drive_wr(1'b1, 1'b0, 5'd4, 32'h0000_0009, 32'h0);
    #1;
    check("pre_rst_r3", 64'(ReadData1_out), 64'h7);
    check("pre_rst_count", 64'(WriteCount_out), 64'd6);
    Reset_n_in = 1'b0;
    #1;
    check("midrst_rd1_forced0", 64'(ReadData1_out), 64'h0);
    check("midrst_rd2_nobyp", 64'(ReadData2_out), 64'h0);
    tick();
    Reset_n_in = 1'b1;
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check("midrst_r3", 64'(ReadData1_out), 64'h0);
    check("midrst_r4", 64'(ReadData2_out), 64'h0);
    check("midrst_count", 64'(WriteCount_out), 64'd0);
    drive_wr(1'b1, 1'b0, 5'd4, 32'h0000_0009, 32'h0);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check("post_rst_r4", 64'(ReadData2_out), 64'h9);
    check("post_rst_count", 64'(WriteCount_out), 64'd1);

    // Counter wrap on the 4-bit instance: 14 more commits reach 0xF, one more wraps
    for (int k = 0; k < 14; k++) begin
      drive_wr(1'b1, 1'b0, 5'(11 + k), 32'(k), 32'h0);
      tick();
    end
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    check("wrap_pre_small", 64'(s_cnt), 64'hF);
    drive_wr(1'b1, 1'b1, 5'd31, 32'h0, 32'h0000_00AB);
    tick();
    drive_wr(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    ReadReg1_in = 5'd31;
    #1;
    check("wrap_small_zero", 64'(s_cnt), 64'h0);
    check("wrap_main_count", 64'(WriteCount_out), 64'd16);
    check("wrap_r31", 64'(ReadData1_out), 64'hAB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
